// File: rtl/power_event_detector_pkg.sv
// power_event_detector_pkg
//   Shared definitions for the power event detector and its baseline tracker.
//   - PWR_W: power sample width, shared with the band-power stage.
//   - DEF_*: default parameter values for the detector.
//   - pe_state_t: detector state encoding (WARMUP=0, IDLE=1, ACTIVE=2, REFRACT=3).
//   - sat_inc16: saturating 16-bit increment used by the event counter.
package power_event_detector_pkg;

  localparam int unsigned PWR_W            = 16;
  localparam int unsigned DEF_ALPHA_SHIFT  = 3;
  localparam int unsigned DEF_MARGIN_SHIFT = 1;
  localparam int unsigned DEF_FLOOR        = 16;
  localparam int unsigned DEF_WARMUP       = 8;
  localparam int unsigned DEF_REFRACT      = 4;

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_REFRACT = 2'd3
  } pe_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/power_event_detector_ema.sv
// ema_baseline
//   Exponential moving average of the clamped power, weight 2^-ALPHA_SHIFT.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     clear      : synchronous zeroing of the accumulator
//     upd        : apply one update with p (frozen when low)
//     seed       : with upd, load acc = p << ALPHA_SHIFT instead of updating
//     p          : clamped (non-negative) power sample
//     baseline   : acc >> ALPHA_SHIFT
module ema_baseline
  import power_event_detector_pkg::*;
#(
  parameter int unsigned W           = PWR_W,
  parameter int unsigned ALPHA_SHIFT = DEF_ALPHA_SHIFT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         upd,
  input  logic         seed,
  input  logic [W-1:0] p,
  output logic [W-1:0] baseline
);

  localparam int unsigned AW = W + ALPHA_SHIFT;

  logic [AW-1:0] acc;
  logic [AW-1:0] p_ext;

  assign p_ext    = AW'(p);
  assign baseline = acc[AW-1:ALPHA_SHIFT];

  // acc never exceeds p_max << ALPHA_SHIFT, so AW bits cannot overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (upd) begin
      if (seed) acc <= p_ext << ALPHA_SHIFT;
      else      acc <= acc - (acc >> ALPHA_SHIFT) + p_ext;
    end
  end

endmodule

// File: rtl/power_event_detector.sv
// power_event_detector
//   Flags band-power windows that rise above a slowly tracking baseline,
//   with hysteresis (on/off thresholds) and a refractory period.
//   Optional feature macro: POWER_EVENT_STATS_EN (event_count / peak_power).
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     clear        : synchronous restart to warm-up (sample in same cycle dropped)
//     power_valid  : one-cycle strobe qualifying power_in
//     power_in     : signed window power
//     event_pulse  : one-cycle pulse on each detection onset ("event" is a
//                    reserved word, hence the longer name)
//     active       : high from onset until the cycle after the release sample
//     baseline_out : current baseline
//     event_count  : saturating onset count (0 without POWER_EVENT_STATS_EN)
//     peak_power   : max power in current/last event (0 without the macro)
module power_event_detector
  import power_event_detector_pkg::*;
#(
  parameter int unsigned W            = PWR_W,
  parameter int unsigned ALPHA_SHIFT  = DEF_ALPHA_SHIFT,
  parameter int unsigned MARGIN_SHIFT = DEF_MARGIN_SHIFT,
  parameter int unsigned FLOOR        = DEF_FLOOR,
  parameter int unsigned WARMUP       = DEF_WARMUP,
  parameter int unsigned REFRACT      = DEF_REFRACT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                power_valid,
  input  logic signed [W-1:0] power_in,
  output logic                event_pulse,
  output logic                active,
  output logic [W-1:0]        baseline_out,
  output logic [15:0]         event_count,
  output logic [W-1:0]        peak_power
);

  localparam int unsigned WC_W = (WARMUP  < 2) ? 1 : $clog2(WARMUP + 1);
  localparam int unsigned RC_W = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);
  localparam logic [WC_W-1:0] WARM_LAST = (WARMUP == 0) ? '0 : WC_W'(WARMUP - 1);
  localparam logic [RC_W-1:0] REF_LOAD  = RC_W'(REFRACT);

  pe_state_t       state;
  logic [WC_W-1:0] warm_cnt;
  logic [RC_W-1:0] ref_cnt;

  logic [W-1:0]   p;
  logic [W-1:0]   base;
  logic [W+1:0]   base_x;
  logic [W+1:0]   p_x;
  logic [W+1:0]   on_th;
  logic [W+1:0]   off_th;
  logic           above_on;
  logic           above_off;
  logic           onset;
  logic           ema_upd;
  logic           ema_seed;

  // Negative power is meaningless here; clamp to zero.
  assign p = power_in[W-1] ? '0 : W'($unsigned(power_in));

  assign base_x = {2'b00, base};
  assign p_x    = {2'b00, p};
  assign on_th  = base_x + (base_x >> MARGIN_SHIFT) + (W+2)'(FLOOR);
  assign off_th = base_x + (W+2)'(FLOOR);

  assign above_on  = p_x > on_th;
  assign above_off = p_x > off_th;

  assign onset = power_valid && !clear && (state == ST_IDLE) && above_on;

  // Baseline moves only in WARMUP and in IDLE when no onset occurs; the
  // comparisons above use the pre-update value held in the accumulator.
  assign ema_upd  = power_valid && !clear &&
                    ((state == ST_WARMUP) || ((state == ST_IDLE) && !above_on));
  assign ema_seed = (state == ST_WARMUP) && (warm_cnt == '0);

  ema_baseline #(
    .W           (W),
    .ALPHA_SHIFT (ALPHA_SHIFT)
  ) u_ema (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .upd      (ema_upd),
    .seed     (ema_seed),
    .p        (p),
    .baseline (base)
  );

  assign baseline_out = base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_WARMUP;
      warm_cnt    <= '0;
      ref_cnt     <= '0;
      event_pulse <= 1'b0;
      active      <= 1'b0;
    end else begin
      event_pulse <= 1'b0;
      if (clear) begin
        state    <= ST_WARMUP;
        warm_cnt <= '0;
        ref_cnt  <= '0;
        active   <= 1'b0;
      end else if (power_valid) begin
        case (state)
          ST_WARMUP: begin
            warm_cnt <= warm_cnt + WC_W'(1);
            if (warm_cnt >= WARM_LAST) state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (above_on) begin
              state       <= ST_ACTIVE;
              event_pulse <= 1'b1;
              active      <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (!above_off) begin
              active <= 1'b0;
              if (REFRACT == 0) begin
                state <= ST_IDLE;
              end else begin
                state   <= ST_REFRACT;
                ref_cnt <= REF_LOAD;
              end
            end
          end
          ST_REFRACT: begin
            if (ref_cnt <= RC_W'(1)) begin
              ref_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              ref_cnt <= ref_cnt - RC_W'(1);
            end
          end
          default: state <= ST_WARMUP;
        endcase
      end
    end
  end

`ifdef POWER_EVENT_STATS_EN
  logic [15:0]  evt_cnt;
  logic [W-1:0] peak;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt <= '0;
      peak    <= '0;
    end else if (clear) begin
      evt_cnt <= '0;
      peak    <= '0;
    end else if (onset) begin
      evt_cnt <= sat_inc16(evt_cnt);
      peak    <= p;
    end else if (power_valid && (state == ST_ACTIVE) && (p > peak)) begin
      peak <= p;
    end
  end

  assign event_count = evt_cnt;
  assign peak_power  = peak;
`else
  assign event_count = '0;
  assign peak_power  = '0;
`endif

endmodule

// File: tb/tb_power_event_detector.sv
module tb_power_event_detector;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic               power_valid = 1'b0;
  logic signed [15:0] power_in = '0;
  logic               event_pulse;
  logic               active;
  logic [15:0]        baseline_out;
  logic [15:0]        event_count;
  logic [15:0]        peak_power;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  power_event_detector dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .power_valid  (power_valid),
    .power_in     (power_in),
    .event_pulse  (event_pulse),
    .active       (active),
    .baseline_out (baseline_out),
    .event_count  (event_count),
    .peak_power   (peak_power)
  );

  // Reference model: baseline as an EMA accumulator, phases as counters.
  int m_acc, m_warm, m_ref, m_cnt, m_peak;
  bit m_act, m_evt;

  function automatic void m_reset();
    m_acc = 0; m_warm = 0; m_ref = 0; m_cnt = 0; m_peak = 0;
    m_act = 0; m_evt = 0;
  endfunction

  function automatic void m_step(input bit v, input int raw, input bit clr);
    int p, base, on_th, off_th;
    m_evt = 0;
    if (clr) begin m_reset(); return; end
    if (!v) return;
    p      = (raw < 0) ? 0 : raw;
    base   = m_acc / 8;
    on_th  = base + base / 2 + 16;
    off_th = base + 16;
    if (m_warm < 8) begin
      m_acc = (m_warm == 0) ? p * 8 : m_acc - m_acc / 8 + p;
      m_warm++;
    end else if (m_act) begin
      if (p > m_peak) m_peak = p;
      if (p <= off_th) begin m_act = 0; m_ref = 4; end
    end else if (m_ref > 0) begin
      m_ref--;
    end else if (p > on_th) begin
      m_act = 1; m_evt = 1; m_peak = p;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_acc = m_acc - m_acc / 8 + p;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic chk_all(input string tag);
    int exp_cnt, exp_peak;
`ifdef POWER_EVENT_STATS_EN
    exp_cnt = m_cnt; exp_peak = m_peak;
`else
    exp_cnt = 0; exp_peak = 0;
`endif
    chk({tag, ".event"},    32'(event_pulse),  32'(m_evt));
    chk({tag, ".active"},   32'(active),       32'(m_act));
    chk({tag, ".baseline"}, 32'(baseline_out), 32'(m_acc / 8));
    chk({tag, ".count"},    32'(event_count),  32'(exp_cnt));
    chk({tag, ".peak"},     32'(peak_power),   32'(exp_peak));
  endtask

  task automatic step(input bit v, input int val, input bit clr, input string tag);
    @(negedge clk);
    power_valid = v;
    power_in    = 16'(val);
    clear       = clr;
    @(posedge clk);
    #1;
    power_valid = 1'b0;
    clear       = 1'b0;
    m_step(v, val, clr);
    chk_all(tag);
  endtask

  initial begin
    int n;
    m_reset();
    #12;
    chk_all("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    // Warm-up: baseline converges to exactly 100, no events.
    for (int i = 0; i < 8; i++) step(1'b1, 100, 1'b0, "warm");
    chk("warm.baseline100", 32'(baseline_out), 32'd100);

    // Onset / hold / release.
    step(1'b1, 200, 1'b0, "on200");
    chk("on200.event_lit", 32'(event_pulse), 32'd1);
    step(1'b0, 0, 1'b0, "gap");
    chk("gap.event_drop", 32'(event_pulse), 32'd0);
    step(1'b1, 150, 1'b0, "hold150");
    chk("hold150.active_lit", 32'(active), 32'd1);
    step(1'b1, 100, 1'b0, "rel100");
    chk("rel100.active_lit", 32'(active), 32'd0);

    // Refractory: four ignored windows, fifth detects.
    for (int i = 0; i < 4; i++) step(1'b1, 300, 1'b0, "refr300");
    chk("refr.baseline_lit", 32'(baseline_out), 32'd100);
    step(1'b1, 300, 1'b0, "fifth300");
    chk("fifth300.event_lit", 32'(event_pulse), 32'd1);
    step(1'b1, 100, 1'b0, "rel2");
    for (int i = 0; i < 4; i++) step(1'b1, 100, 1'b0, "refr2");

    // Negative input clamps to zero; baseline decays to 0.
    n = 0;
    while (m_acc / 8 != 0 && n < 300) begin
      step(1'b1, -500, 1'b0, "neg");
      n++;
    end
    chk("neg.baseline_zero", 32'(baseline_out), 32'd0);
    step(1'b1, 17, 1'b0, "p17");
    chk("p17.event_lit", 32'(event_pulse), 32'd1);

    // Asynchronous reset mid-event.
    chk("pre_rst.active", 32'(active), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Clear with a coincident valid drops the sample and restarts warm-up.
    for (int i = 0; i < 3; i++) step(1'b1, 400, 1'b0, "prewarm");
    step(1'b1, 999, 1'b1, "clear_valid");
    for (int i = 0; i < 8; i++) step(1'b1, 50, 1'b0, "rewarm");
    chk("rewarm.baseline50", 32'(baseline_out), 32'd50);

`ifdef POWER_EVENT_STATS_EN
    // Saturation of the event counter.
    @(negedge clk);
    force dut.evt_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.evt_cnt;
    m_cnt = 65535;
    step(1'b1, 200, 1'b0, "sat_evt");
    chk("sat.count_lit", 32'(event_count), 32'hFFFF);
    step(1'b1, 0, 1'b0, "sat_rel");
    for (int i = 0; i < 4; i++) step(1'b1, 0, 1'b0, "sat_refr");
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 500)) - 100,
           $urandom_range(0, 60) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/power_event_detector.md
# power_event_detector

Consumes the windowed band-power stream (one signed 16-bit power value per `done` pulse) and flags windows whose power rises significantly above a slowly tracking baseline. It sits directly downstream of the band-power stage and feeds the beat/event logic with a one-cycle `event` pulse and an `active` level. Detection uses hysteresis and a refractory period.

## Interface
- `W`, 16: power sample width.
- `ALPHA_SHIFT`, 3: baseline EMA weight is 2^-ALPHA_SHIFT.
- `MARGIN_SHIFT`, 1: on-threshold margin is baseline >> MARGIN_SHIFT.
- `FLOOR`, 16: absolute offset added to both thresholds.
- `WARMUP`, 8: windows used only to build the baseline after reset or clear.
- `REFRACT`, 4: windows ignored after an event ends. 0 means none.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous restart to WARMUP. Baseline and counters are zeroed.
- `power_valid` in 1: one-cycle strobe. Driven from the upstream `done`.
- `power_in` in W signed: window power. Sampled when `power_valid`=1.
- `event` out 1: one-cycle pulse on each detection onset.
- `active` out 1: high from onset until the release window.
- `baseline_out` out W: current baseline (unsigned value).
- `event_count` out 16: saturating detection count. Present only with the STATS macro.
- `peak_power` out W: maximum power seen during the current or last event. Present only with the STATS macro.

## Operation
- Input conditioning:
  - Negative `power_in` is clamped to 0.
  - p denotes the clamped unsigned value.
- Baseline:
  - acc is an unsigned register of W+ALPHA_SHIFT bits.
  - Update rule: acc <= acc - (acc >> ALPHA_SHIFT) + p.
  - baseline = acc >> ALPHA_SHIFT.
  - The first valid after reset or clear seeds acc = p << ALPHA_SHIFT.
  - The baseline updates only in WARMUP and IDLE. It is frozen in ACTIVE and REFRACT.
- Thresholds are computed in W+2 bits with no saturation:
  - on_th = base + (base >> MARGIN_SHIFT) + FLOOR
  - off_th = base + FLOOR
- States and transitions (each transition evaluated on `power_valid` only):
  - WARMUP: update the baseline and increment warm_cnt. Go to IDLE on the WARMUP-th valid. No detection in this state.
  - IDLE: if p > on_th, go to ACTIVE, pulse `event`, increment the count and set peak = p. Otherwise update the baseline.
  - ACTIVE: track peak = max(peak, p). If p <= off_th, go to REFRACT with ref_cnt = REFRACT. If REFRACT = 0, go straight to IDLE instead.
  - REFRACT: decrement ref_cnt on each valid. On the valid where ref_cnt reaches 0, go to IDLE. No detection in this state.
- Comparisons use the baseline value held before the current sample's update.
- `clear` takes priority over `power_valid` in the same cycle; that sample is dropped.
- `event_count` saturates at 0xFFFF.

## Timing
- All outputs are registered.
- `event`, `active` and `baseline_out` reflect a sample on the cycle after its `power_valid`. Latency is 1 cycle.
- A `power_valid` can be accepted every cycle. There is no backpressure.
- `event` is high for exactly one cycle per onset.
- `active` rises together with `event`. It falls the cycle after the release sample.
- Reset (asynchronous `rst`) values:
  - state = WARMUP.
  - acc, warm_cnt and ref_cnt = 0.
  - `event`, `active`, `baseline_out`, `event_count` and `peak_power` = 0.
- `rst` asserted mid-event clears `active` immediately. It does not wait for the clock.
- `clear` behaves the same as reset, but takes effect on the next clock edge.

## Configuration
- Macro: `POWER_EVENT_STATS_EN`.
- Defined: the `event_count` and `peak_power` registers and their logic are built.
- Undefined: both ports still exist but are tied to 0, and no registers are inferred. Detection behaviour is identical in both cases.

## Structure
- Shared package/header holds:
  - state encodings (WARMUP=0, IDLE=1, ACTIVE=2, REFRACT=3);
  - default parameter constants;
  - the power width W, shared with the band-power stage.
- Natural sub-module: `ema_baseline`.
  - Contains the seed/update/freeze logic.
  - Ports: clk, rst, clear, upd, seed, p, baseline.
- The FSM, thresholds and stats stay in the top level.

## Test plan
- Reset, then feed 8 windows of 100 → `baseline_out`=100 exactly. State is IDLE and `event` never fires during warm-up.
- After warm-up (on_th=166, off_th=116), feed 200 → `event` is a one-cycle pulse the cycle after the valid, `active`=1 and `event_count`=1. Then feed 150 → `active` stays 1. Then feed 100 → `active`=0 and `peak_power`=200.
- Refractory: after the release, feed 300 ×4 → no `event`, baseline stays 100. The 5th 300 → `event` and `event_count`=2.
- `power_in`=-500 in IDLE → treated as 0, the baseline drops toward 0 and there is no event. A later 17 with baseline 0 exceeds on_th=16 → `event`.
- Assert `rst` asynchronously while `active`=1 → all outputs are 0 before the next edge. Assert `clear` together with `power_valid` → the sample is dropped and warm-up restarts.
- STATS: force the count to 0xFFFF, then trigger another event → it stays 0xFFFF. Build without `POWER_EVENT_STATS_EN` → `event_count` and `peak_power` stay 0.
